// File: rtl/instr_mem.sv
// instr_mem: instruction memory with a one-deep registered fetch response, a program-load write port
// and an out-of-range flag; an out-of-range fetch returns FILL_INSTR.
module instr_mem #(
    parameter int                ADDR_W     = 4,
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 2**ADDR_W,
    parameter logic [DATA_W-1:0] FILL_INSTR = DATA_W'(8'b00111000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_instr,
    output logic [ADDR_W-1:0] resp_addr,
    input  logic              resp_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              err_oob
);
    // Widened by one bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic              fire, req_ok, wr_ok, wr_hit;
    logic [DATA_W-1:0] rd_data;
    assign req_ready = !resp_valid || resp_ready;
    assign fire      = req_valid && req_ready;
    assign req_ok    = {1'b0, req_addr} < LIMIT;
    assign wr_ok     = {1'b0, wr_addr} < LIMIT;
    assign wr_hit    = wr_en && wr_ok && (wr_addr == req_addr);
    // A write landing on the address being fetched is forwarded (write-first).
    assign rd_data   = !req_ok ? FILL_INSTR : (wr_hit ? wr_data : mem[req_addr]);
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_instr <= FILL_INSTR;
            resp_addr  <= '0;
            err_oob    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= FILL_INSTR;
        end else begin
            if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
            if (fire) begin
                resp_valid <= 1'b1;
                resp_addr  <= req_addr;
                resp_instr <= rd_data;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            err_oob <= (fire && !req_ok) || (wr_en && !wr_ok);
        end
    end
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: directed scoreboard bench for instr_mem built with DEPTH=10, so that both the
// in-range edge (address 9) and out-of-range addresses (10 and above) can be exercised.
module tb_instr_mem;
    localparam int DEPTH = 10;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, resp_ready = 1'b0, wr_en = 1'b0;
    logic [3:0] req_addr = '0, wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       req_ready, resp_valid, err_oob;
    logic [7:0] resp_instr;
    logic [3:0] resp_addr;
    int checks = 0, errors = 0;
    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } exp_t;
    exp_t       q[$];
    logic [7:0] model [DEPTH];
    logic       m_valid = 1'b0, m_oob = 1'b0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_instr = 8'h38;

    instr_mem #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_instr(resp_instr),
        .resp_addr(resp_addr), .resp_ready(resp_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, update the model, push the expected response if the request fires,
    // then after the edge pop it and compare the DUT outputs.
    task automatic step(input logic rv, input logic [3:0] ra, input logic rr,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd);
        logic exp_ready, fired;
        exp_t e;
        req_valid = rv; req_addr = ra; resp_ready = rr;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
        exp_ready = !m_valid || rr;
        check("req_ready", {7'd0, req_ready}, {7'd0, exp_ready});
        m_oob = 1'b0;
        if (we) begin
            if (int'(wa) < DEPTH) model[wa] = wd;
            else m_oob = 1'b1;
        end
        fired = rv && exp_ready;
        if (fired) begin
            q.push_back('{a: ra, d: (int'(ra) < DEPTH) ? model[ra] : 8'h38});
            if (int'(ra) >= DEPTH) m_oob = 1'b1;
        end
        @(posedge clk);
        #1;
        if (fired) begin
            e = q.pop_front();
            m_valid = 1'b1; m_addr = e.a; m_instr = e.d;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        check("resp_valid", {7'd0, resp_valid}, {7'd0, m_valid});
        if (m_valid) begin
            check("resp_addr", {4'd0, resp_addr}, {4'd0, m_addr});
            check("resp_instr", resp_instr, m_instr);
        end
        check("err_oob", {7'd0, err_oob}, {7'd0, m_oob});
    endtask

    // Reset is held with a request and a write pending; both must be dropped.
    task automatic do_reset(input int n);
        reset = 1'b1; req_valid = 1'b1; req_addr = 4'd5; resp_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
        repeat (n) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h38;
        m_valid = 1'b0; m_oob = 1'b0; q.delete();
        check("rst_valid", {7'd0, resp_valid}, 8'd0);
        check("rst_instr", resp_instr, 8'h38);
        check("rst_addr", {4'd0, resp_addr}, 8'd0);
        check("rst_oob", {7'd0, err_oob}, 8'd0);
        reset = 1'b0; req_valid = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        do_reset(2);
        // fetch of unwritten location returns the fill instruction
        step(1, 4'd3, 1, 0, 4'd0, 8'h00);
        step(0, 4'd0, 1, 0, 4'd0, 8'h00);
        // program load, then back-to-back fetches
        step(0, 4'd0, 1, 1, 4'd0, 8'h1C);
        step(0, 4'd0, 1, 1, 4'd1, 8'h02);
        step(0, 4'd0, 1, 1, 4'd2, 8'h01);
        step(1, 4'd0, 1, 0, 4'd0, 8'h00);
        step(1, 4'd1, 1, 0, 4'd0, 8'h00);
        step(1, 4'd2, 1, 0, 4'd0, 8'h00);
        step(0, 4'd0, 1, 0, 4'd0, 8'h00);
        // stall: held response is unaffected by a write to its address
        step(1, 4'd1, 0, 0, 4'd0, 8'h00);
        step(1, 4'd1, 0, 1, 4'd1, 8'hFF);
        step(1, 4'd1, 0, 0, 4'd0, 8'h00);
        step(1, 4'd1, 0, 0, 4'd0, 8'h00);
        step(1, 4'd1, 1, 0, 4'd0, 8'h00);
        step(0, 4'd0, 1, 0, 4'd0, 8'h00);
        // same-cycle fetch and write
        step(1, 4'd4, 1, 1, 4'd4, 8'hB0);
        // last implemented location
        step(0, 4'd0, 1, 1, 4'd9, 8'h77);
        step(1, 4'd9, 1, 0, 4'd0, 8'h00);
        // out-of-range fetches and writes
        step(1, 4'd12, 1, 0, 4'd0, 8'h00);
        step(0, 4'd0, 1, 0, 4'd0, 8'h00);
        step(1, 4'd10, 1, 0, 4'd0, 8'h00);
        step(0, 4'd0, 1, 1, 4'd15, 8'hAA);
        step(0, 4'd0, 1, 0, 4'd0, 8'h00);
        step(1, 4'd5, 1, 0, 4'd0, 8'h00);
        step(1, 4'd13, 1, 1, 4'd11, 8'hAA);
        step(0, 4'd0, 1, 0, 4'd0, 8'h00);
        // reset during a stall discards the response and reloads the fill value
        step(1, 4'd0, 0, 0, 4'd0, 8'h00);
        step(0, 4'd0, 0, 0, 4'd0, 8'h00);
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) step(1, 4'(i), 1, 0, 4'd0, 8'h00);
        step(0, 4'd0, 1, 0, 4'd0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the instruction width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_W, giving the number of implemented locations; legal range is 1..2**ADDR_W.
REQ-004 The block SHALL have parameter FILL_INSTR, default 8'b00111000 (NOP), used as the reset and out-of-range value.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-007 Port: reset  input  1  synchronous, active-high reset.
REQ-008 Port: req_valid  input  1  fetch request present.
REQ-009 Port: req_addr  input  ADDR_W  fetch address.
REQ-010 Port: req_ready  output  1  fetch request accepted this cycle when high with req_valid.
REQ-011 Port: resp_valid  output  1  resp_instr/resp_addr hold a fetched result.
REQ-012 Port: resp_instr  output  DATA_W  fetched instruction.
REQ-013 Port: resp_addr  output  ADDR_W  address the result belongs to.
REQ-014 Port: resp_ready  input  1  consumer accepts the response this cycle.
REQ-015 Port: wr_en  input  1  program-load write strobe.
REQ-016 Port: wr_addr  input  ADDR_W  write address.
REQ-017 Port: wr_data  input  DATA_W  write data.
REQ-018 Port: err_oob  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-019 Storage SHALL be DEPTH words of DATA_W bits; reads are registered, with no combinational path from req_addr to resp_instr.
REQ-020 req_ready SHALL equal (!resp_valid || resp_ready), combinationally.
REQ-021 A request fires when req_valid && req_ready; on the next edge resp_valid=1, resp_addr=req_addr and resp_instr=mem[req_addr] (latency 1 cycle).
REQ-022 The response SHALL fire when resp_valid && resp_ready; if no new request fires in that cycle, resp_valid SHALL clear on the next edge.
REQ-023 Back-to-back: when a response fires and a new request fires in the same cycle, resp_valid SHALL stay 1 and the outputs SHALL update to the new request, giving one fetch per cycle.
REQ-024 While resp_valid=1 and resp_ready=0, resp_instr and resp_addr SHALL hold stable; no request is accepted.
REQ-025 A write with wr_en=1 and wr_addr<DEPTH SHALL update mem[wr_addr] at the edge; writes are independent of the fetch handshake.
REQ-026 Write-first: if a firing request and a write target the same address in the same cycle, resp_instr SHALL return wr_data.
REQ-027 A write to an address not fired on SHALL NOT alter a held response (REQ-024), even if it targets resp_addr.
REQ-028 A fired request with req_addr>=DEPTH SHALL return resp_instr=FILL_INSTR and pulse err_oob for one cycle, aligned with resp_valid rising or updating.
REQ-029 A write with wr_addr>=DEPTH SHALL be ignored and SHALL pulse err_oob on the next cycle.
REQ-030 Out-of-range fetch and out-of-range write in the same cycle SHALL produce a single err_oob pulse.
REQ-031 Address arithmetic SHALL be unsigned ADDR_W bits; the block does no address increment or wrap.

Reset
REQ-032 While reset=1 at an edge: resp_valid=0, resp_instr=FILL_INSTR, resp_addr=0, err_oob=0, and every mem location SHALL be set to FILL_INSTR.
REQ-033 Reset SHALL take priority over a concurrent request or write; both are dropped.
REQ-034 Reset asserted with a response pending SHALL discard that response; req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-035 Reset, then fetch addr 3 with resp_ready=1 -> one cycle later resp_valid=1, resp_addr=3, resp_instr=8'h38.
REQ-036 Write 8'h1C@0, 8'h02@1, 8'h01@2, then fetch 0,1,2 on consecutive cycles with resp_ready=1 -> responses 1C, 02, 01 on three consecutive cycles, resp_valid continuously 1.
REQ-037 Fetch 1 with resp_ready=0 for 3 cycles while writing 8'hFF@1 -> resp_instr holds 8'h02, req_ready=0; after resp_ready=1 a new fetch of 1 returns 8'hFF.
REQ-038 Same-cycle fetch and write of 8'hB0 to addr 4 -> resp_instr=8'hB0.
REQ-039 DEPTH=10: fetch addr 12 -> resp_instr=8'h38, err_oob pulses once; write 8'hAA@15 -> ignored, err_oob pulses once.
REQ-040 Assert reset mid-stall with resp_valid=1 -> resp_valid=0 next cycle, all locations read 8'h38 afterwards.
